data_path_param: RTL

Parametrised successor to the fixed 16-bit accumulator data path. It holds PC, IR, ACC, an NREG-entry general register file, an ALU and an N/Z/C/V flag register. The sequencer drives it through a one-hot control vector plus encoded `alu_op` and `reg_sel` fields. It sits between the control unit and the memory read/write buses.

---
 rtl/data_path_param_pkg.sv | 42 ++++
 rtl/data_path_param_alu.sv | 51 +++++
 rtl/data_path_param.sv | 124 ++++++++++++
 3 files changed

// File: rtl/data_path_param_pkg.sv
// Shared definitions for the parametrised accumulator data path.
// Holds the control-line indices for the one-hot control vector, the ALU
// operation codes and the packed flag-register type. No ports.
package data_path_param_pkg;

    // Control-line indices into control[0:DP_CTRL_LINES-1]
    localparam int DP_CTRL_LINES = 15;
    localparam int INIT_PC   = 0;
    localparam int INC_PC    = 1;
    localparam int PC_REG    = 2;
    localparam int PC_IR     = 3;
    localparam int IR_RBUS   = 4;
    localparam int REG_RBUS  = 5;
    localparam int REG_ACC   = 6;
    localparam int ACC_RBUS  = 7;
    localparam int ACC_ALU   = 8;
    localparam int FLAGS_CLR = 9;
    localparam int ABUS_PC   = 10;
    localparam int ABUS_IR   = 11;
    localparam int ABUS_REG  = 12;
    localparam int WBUS_ACC  = 13;
    localparam int WBUS_REG  = 14;

    // ALU operation codes; unlisted codes act as PASS_B
    localparam logic [3:0] ALU_PASS_B = 4'd0;
    localparam logic [3:0] ALU_ADD    = 4'd1;
    localparam logic [3:0] ALU_SUB    = 4'd2;
    localparam logic [3:0] ALU_AND    = 4'd3;
    localparam logic [3:0] ALU_OR     = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_NOT_A  = 4'd6;
    localparam logic [3:0] ALU_SHL_A  = 4'd7;
    localparam logic [3:0] ALU_SHR_A  = 4'd8;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/data_path_param_alu.sv
// Combinational ALU for the data path: result plus carry and overflow.
// Ports: op (4-bit code), a (ACC), b (selected register) in;
//        result, c, v out. Zero and negative are derived by the parent.
module alu_param
    import data_path_param_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              c,
    output logic              v
);

    localparam int MSB = DATA_W - 1;

    always_comb begin
        result = b;
        c      = 1'b0;
        v      = 1'b0;
        case (op)
            ALU_ADD: begin
                {c, result} = {1'b0, a} + {1'b0, b};
                // overflow: like-signed operands produce an opposite-signed sum
                v = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
            end
            ALU_SUB: begin
                result = a - b;
                // carry means "no borrow"
                c = (a >= b);
                v = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
            end
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_XOR:   result = a ^ b;
            ALU_NOT_A: result = ~a;
            ALU_SHL_A: begin
                result = {a[MSB-1:0], 1'b0};
                c      = a[MSB];
            end
            ALU_SHR_A: begin
                result = {1'b0, a[MSB:1]};
                c      = a[0];
            end
            default:   result = b;
        endcase
    end

endmodule

// File: rtl/data_path_param.sv
// Parametrised accumulator data path: PC, IR, ACC, register file, ALU, flags.
// Ports: clk/rst; control one-hot lines, alu_op, reg_sel from the sequencer;
//        int_rbus in, int_wbus/int_abus out; IR opcode/operand and Z/N/C/V out.
module data_path_param
    import data_path_param_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int OPC_W  = 4,
    parameter int NREG   = 4,
    parameter int RST_PC = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [0:DP_CTRL_LINES-1] control,
    input  logic [3:0]              alu_op,
    input  logic [$clog2(NREG)-1:0] reg_sel,
    output logic [OPC_W-1:0]        IR,
    output logic [ADDR_W-1:0]       IR_operand,
    input  logic [DATA_W-1:0]       int_rbus,
    output logic [DATA_W-1:0]       int_wbus,
    output logic [ADDR_W-1:0]       int_abus,
    output logic                    Z,
    output logic                    N,
    output logic                    C,
    output logic                    V
);

    localparam logic [ADDR_W-1:0] RST_PC_V = RST_PC[ADDR_W-1:0];

    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] regs [NREG];
    flags_t            flags;

    logic [DATA_W-1:0] reg_q;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic              alu_v;
    logic              alu_load;

    assign reg_q = regs[reg_sel];

    alu_param #(.DATA_W(DATA_W)) u_alu (
        .op     (alu_op),
        .a      (acc),
        .b      (reg_q),
        .result (alu_res),
        .c      (alu_c),
        .v      (alu_v)
    );

    // ACC_RBUS wins the ACC, so the ALU result (and its flags) is only
    // committed when the bus load is not also requested.
    assign alu_load = control[ACC_ALU] && !control[ACC_RBUS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= RST_PC_V;
            ir    <= '0;
            acc   <= '0;
            flags <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (control[INIT_PC])
                pc <= RST_PC_V;
            else if (control[PC_IR])
                pc <= ir[ADDR_W-1:0];
            else if (control[PC_REG])
                pc <= reg_q[ADDR_W-1:0];
            else if (control[INC_PC])
                pc <= pc + ADDR_W'(1);

            if (control[IR_RBUS])
                ir <= int_rbus;

            if (control[REG_RBUS])
                regs[reg_sel] <= int_rbus;
            else if (control[REG_ACC])
                regs[reg_sel] <= acc;

            if (control[ACC_RBUS])
                acc <= int_rbus;
            else if (control[ACC_ALU])
                acc <= alu_res;

            if (control[FLAGS_CLR])
                flags <= '0;
            else if (alu_load)
                flags <= '{z: (alu_res == '0), n: alu_res[DATA_W-1], c: alu_c, v: alu_v};
        end
    end

    always_comb begin
        if (control[ABUS_PC])
            int_abus = pc;
        else if (control[ABUS_IR])
            int_abus = ir[ADDR_W-1:0];
        else if (control[ABUS_REG])
            int_abus = reg_q[ADDR_W-1:0];
        else
            int_abus = '0;
    end

    always_comb begin
        if (control[WBUS_ACC])
            int_wbus = acc;
        else if (control[WBUS_REG])
            int_wbus = reg_q;
        else
            int_wbus = '0;
    end

    assign IR         = ir[DATA_W-1 -: OPC_W];
    assign IR_operand = ir[ADDR_W-1:0];
    assign Z          = flags.z;
    assign N          = flags.n;
    assign C          = flags.c;
    assign V          = flags.v;

endmodule
